// File: rtl/e_muldiv_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | e_muldiv_pkg: shared types and helpers for the RV32M mul/div control  |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
package e_muldiv_pkg;

  typedef enum logic [2:0] {
    MUL    = 3'b000,
    MULH   = 3'b001,
    MULHSU = 3'b010,
    MULHU  = 3'b011,
    DIV    = 3'b100,
    DIVU   = 3'b101,
    REM    = 3'b110,
    REMU   = 3'b111
  } muldiv_op_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam int DEF_MUL_LAT = 4;
  localparam int DEF_DIV_LAT = 33;

  function automatic logic is_div(input logic [2:0] op);
    return (op == DIV) || (op == DIVU) || (op == REM) || (op == REMU);
  endfunction

endpackage
`default_nettype wire

// File: rtl/e_lat_counter.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | e_lat_counter: loadable down-counter, terminal flags the last cycle   |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module e_lat_counter #(
  parameter int W = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_value,
  input  logic         clear,
  output logic         terminal
);

  logic [W-1:0] count;

  // Saturates at zero so an idle counter never wraps back to a live value.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - 1'b1;
    end
  end

  assign terminal = (count == W'(1));

endmodule
`default_nettype wire

// File: rtl/e_muldiv_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | e_muldiv_ctrl: execute-stage sequencer for the multi-cycle RV32M unit |
// | Option macro: MULDIV_DIVZERO_FAST_EN (divide-by-zero bypass). Rev 1.0 |
// +-----------------------------------------------------------------------+
module e_muldiv_ctrl
  import e_muldiv_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int MUL_LAT = DEF_MUL_LAT,
  parameter int DIV_LAT = DEF_DIV_LAT
) (
  input  logic            i_clk,
  input  logic            i_rst,
  input  logic            i_req,
  input  logic [2:0]      i_op,
  input  logic [XLEN-1:0] i_rs1,
  input  logic [XLEN-1:0] i_rs2,
  input  logic            i_flush,
  input  logic [XLEN-1:0] i_dp_result,
  output logic            o_dp_start,
  output logic [2:0]      o_dp_op,
  output logic            o_dp_abort,
  output logic            o_pause,
  output logic            o_valid,
  output logic [XLEN-1:0] o_result,
  output logic            o_busy
);

  localparam int MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int CNT_W   = $clog2(MAX_LAT + 1);

  state_e          state;
  logic [2:0]      op_q;
  logic [XLEN-1:0] result_q;
  logic            accept;
  logic            fast;
  logic            start;
  logic            abort;
  logic            terminal;
  logic [CNT_W-1:0] lat_value;

  assign accept = !i_rst && i_req && !i_flush && (state != BUSY);

`ifdef MULDIV_DIVZERO_FAST_EN
  logic [XLEN-1:0] fast_result;
  assign fast        = accept && is_div(i_op) && (i_rs2 == '0);
  // DIV/DIVU yield all-ones, REM/REMU return the dividend.
  assign fast_result = i_op[1] ? i_rs1 : '1;
`else
  logic unused_operands;
  assign fast            = 1'b0;
  assign unused_operands = ^{i_rs1, i_rs2};
`endif

  assign start     = accept && !fast;
  assign abort     = !i_rst && (state == BUSY) && i_flush;
  assign lat_value = is_div(i_op) ? CNT_W'(DIV_LAT) : CNT_W'(MUL_LAT);

  e_lat_counter #(
    .W(CNT_W)
  ) u_lat_counter (
    .clk       (i_clk),
    .rst       (i_rst),
    .load      (start),
    .load_value(lat_value),
    .clear     (abort),
    .terminal  (terminal)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state    <= IDLE;
      op_q     <= '0;
      result_q <= '0;
    end else begin
      case (state)
        BUSY: begin
          if (i_flush) begin
            state <= IDLE;
          end else if (terminal) begin
            result_q <= i_dp_result;
            state    <= DONE;
          end
        end
        default: begin
          if (accept) begin
            op_q  <= i_op;
            state <= fast ? DONE : BUSY;
`ifdef MULDIV_DIVZERO_FAST_EN
            if (fast) begin
              result_q <= fast_result;
            end
`endif
          end else begin
            state <= IDLE;
          end
        end
      endcase
    end
  end

  assign o_dp_start = start;
  assign o_dp_op    = accept ? i_op : op_q;
  assign o_dp_abort = abort;
  assign o_pause    = accept || (!i_rst && (state == BUSY));
  assign o_valid    = (state == DONE);
  assign o_busy     = (state == BUSY);
  assign o_result   = result_q;

endmodule
`default_nettype wire

// File: tb/tb_e_muldiv_ctrl.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | tb_e_muldiv_ctrl: vector table, directed corner cases, random traffic |
// | Rev 1.0                                                               |
// +-----------------------------------------------------------------------+
module tb_e_muldiv_ctrl;

  localparam int XLEN    = 32;
  localparam int MUL_LAT = 4;
  localparam int DIV_LAT = 33;
`ifdef MULDIV_DIVZERO_FAST_EN
  localparam int DZ_CYC = 1;
`else
  localparam int DZ_CYC = DIV_LAT + 1;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic            rst, req, flush;
  logic [2:0]      op;
  logic [31:0]     rs1, rs2, dp_result;
  logic            dp_start, dp_abort, pause, valid, busy;
  logic [2:0]      dp_op;
  logic [31:0]     result;

  e_muldiv_ctrl #(.XLEN(XLEN), .MUL_LAT(MUL_LAT), .DIV_LAT(DIV_LAT)) dut (
    .i_clk(clk), .i_rst(rst), .i_req(req), .i_op(op), .i_rs1(rs1), .i_rs2(rs2),
    .i_flush(flush), .i_dp_result(dp_result), .o_dp_start(dp_start), .o_dp_op(dp_op),
    .o_dp_abort(dp_abort), .o_pause(pause), .o_valid(valid), .o_result(result),
    .o_busy(busy)
  );

  int n_cmp = 0;
  int n_bad = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endfunction

  // RV32M arithmetic, standing in for the datapath.
  function automatic logic [31:0] golden(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] p;
    case (f)
      3'd0: begin p = {32'b0, a} * {32'b0, b}; return p[31:0]; end
      3'd1: begin p = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); return p[63:32]; end
      3'd2: begin p = $signed({{32{a[31]}}, a}) * $signed({32'b0, b}); return p[63:32]; end
      3'd3: begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        return $signed(a) / $signed(b);
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        return $signed(a) % $signed(b);
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Reference model: an accepted op is in flight until its valid cycle.
  bit          m_inflight = 1'b0;
  int          m_end      = 0;
  int          c          = 0;
  logic [31:0] m_res = '0, m_fa = '0, m_fb = '0;
  logic [2:0]  m_opreg = '0, m_fop = '0;

  logic        s_valid, s_start, s_abort, s_pause, s_busy;
  logic [31:0] s_result;

  task automatic tick(input bit rq, input logic [2:0] o, input logic [31:0] a,
                      input logic [31:0] b, input bit fl, input bit r);
    bit busy_now, valid_now, term, acc, fast;
    int lat;
    rst = r; req = rq; op = o; rs1 = a; rs2 = b; flush = fl;
    busy_now  = m_inflight && (c < m_end);
    valid_now = m_inflight && (c == m_end);
    term      = busy_now && (c == m_end - 1);
    dp_result = term ? golden(m_fop, m_fa, m_fb) : $urandom;
    acc       = !r && rq && !fl && !busy_now;
    fast      = 1'b0;
`ifdef MULDIV_DIVZERO_FAST_EN
    fast = acc && o[2] && (b == 0);
`endif
    #3;
    if (!r) begin
      check("dp_start", 32'(dp_start), 32'(acc && !fast));
      check("dp_op",    32'(dp_op),    32'(acc ? o : m_opreg));
      check("dp_abort", 32'(dp_abort), 32'(busy_now && fl));
      check("pause",    32'(pause),    32'(acc || busy_now));
      check("valid",    32'(valid),    32'(valid_now));
      check("busy",     32'(busy),     32'(busy_now));
      check("result",   result,        m_res);
    end
    s_valid = valid; s_start = dp_start; s_abort = dp_abort;
    s_pause = pause; s_busy = busy; s_result = result;
    @(posedge clk);
    #1;
    if (r) begin
      m_inflight = 1'b0; m_res = '0; m_opreg = '0;
    end else if (busy_now && fl) begin
      m_inflight = 1'b0;
    end else begin
      if (term) m_res = dp_result;
      if (valid_now) m_inflight = 1'b0;
      if (acc) begin
        lat = o[2] ? DIV_LAT : MUL_LAT;
        m_opreg = o; m_fop = o; m_fa = a; m_fb = b; m_inflight = 1'b1;
        m_end = fast ? c + 1 : c + lat + 1;
        if (fast) m_res = o[1] ? a : 32'hFFFF_FFFF;
      end
    end
    c++;
  endtask

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          exp_cycles;
    logic [31:0] exp_res;
  } vec_t;

  vec_t vecs[10];

  initial begin
    int first_k, nvalid;
    vecs[0] = '{3'd0, 32'd6,          32'd7,          MUL_LAT + 1, 32'd42};
    vecs[1] = '{3'd5, 32'd100,        32'd7,          DIV_LAT + 1, 32'd14};
    vecs[2] = '{3'd7, 32'd100,        32'd7,          DIV_LAT + 1, 32'd2};
    vecs[3] = '{3'd1, 32'h8000_0000,  32'd2,          MUL_LAT + 1, 32'hFFFF_FFFF};
    vecs[4] = '{3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  MUL_LAT + 1, 32'hFFFF_FFFE};
    vecs[5] = '{3'd2, 32'hFFFF_FFFF,  32'd2,          MUL_LAT + 1, 32'hFFFF_FFFF};
    vecs[6] = '{3'd4, 32'hFFFF_FFF9,  32'd2,          DIV_LAT + 1, 32'hFFFF_FFFD};
    vecs[7] = '{3'd6, 32'hFFFF_FFF9,  32'd2,          DIV_LAT + 1, 32'hFFFF_FFFF};
    vecs[8] = '{3'd4, 32'd5,          32'd0,          DZ_CYC,      32'hFFFF_FFFF};
    vecs[9] = '{3'd7, 32'd5,          32'd0,          DZ_CYC,      32'd5};

    rst = 1'b1; req = 1'b0; flush = 1'b0; op = '0; rs1 = '0; rs2 = '0; dp_result = '0;
    @(posedge clk);
    #1;
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    check("reset_valid", 32'(s_valid), 32'd0);
    check("reset_pause", 32'(s_pause), 32'd0);
    check("reset_busy",  32'(s_busy),  32'd0);
    check("reset_result", s_result,    32'd0);

    // Table: request held while stalled, dropped on the expected valid cycle.
    foreach (vecs[i]) begin
      first_k = -1;
      for (int k = 0; k <= vecs[i].exp_cycles + 4; k++) begin
        tick(k < vecs[i].exp_cycles, vecs[i].op, vecs[i].a, vecs[i].b, 0, 0);
        if (s_valid && first_k < 0) begin
          first_k = k;
          check($sformatf("vec%0d_result", i), s_result, vecs[i].exp_res);
        end
      end
      check($sformatf("vec%0d_latency", i), 32'(first_k), 32'(vecs[i].exp_cycles));
    end

    // Back-to-back MUL: second op accepted in the DONE cycle.
    for (int k = 0; k < MUL_LAT + 1; k++) tick(1, 3'd0, 32'd6, 32'd7, 0, 0);
    tick(1, 3'd0, 32'd3, 32'd5, 0, 0);
    check("b2b_first_valid",  32'(s_valid), 32'd1);
    check("b2b_first_result", s_result,     32'd42);
    check("b2b_restart",      32'(s_start), 32'd1);
    for (int k = 0; k < MUL_LAT; k++) tick(1, 3'd0, 32'd3, 32'd5, 0, 0);
    check("b2b_still_paused", 32'(s_pause), 32'd1);
    tick(0, 0, 0, 0, 0, 0);
    check("b2b_second_valid",  32'(s_valid), 32'd1);
    check("b2b_second_result", s_result,     32'd15);
    for (int k = 0; k < 3; k++) tick(0, 0, 0, 0, 0, 0);

    // Flush two cycles into a DIV.
    tick(1, 3'd4, 32'd100, 32'd7, 0, 0);
    tick(1, 3'd4, 32'd100, 32'd7, 0, 0);
    tick(1, 3'd4, 32'd100, 32'd7, 1, 0);
    check("flush_abort", 32'(s_abort), 32'd1);
    tick(0, 0, 0, 0, 0, 0);
    check("flush_pause_low", 32'(s_pause), 32'd0);
    nvalid = 0;
    for (int k = 0; k < DIV_LAT + 4; k++) begin
      tick(0, 0, 0, 0, 0, 0);
      if (s_valid) nvalid++;
    end
    check("flush_no_valid", 32'(nvalid), 32'd0);
    tick(1, 3'd0, 32'd1, 32'd1, 1, 0);
    check("flush_idle_no_start", 32'(s_start), 32'd0);
    check("flush_idle_no_abort", 32'(s_abort), 32'd0);

    // Reset three cycles into a MUL, then a fresh op.
    for (int k = 0; k < 3; k++) tick(1, 3'd0, 32'd9, 32'd9, 0, 0);
    tick(1, 3'd0, 32'd9, 32'd9, 0, 1);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_mid_pause",  32'(s_pause), 32'd0);
    check("rst_mid_busy",   32'(s_busy),  32'd0);
    check("rst_mid_valid",  32'(s_valid), 32'd0);
    check("rst_mid_result", s_result,     32'd0);
    tick(1, 3'd0, 32'd2, 32'd3, 0, 0);
    check("rst_fresh_start", 32'(s_start), 32'd1);
    for (int k = 0; k < MUL_LAT; k++) tick(1, 3'd0, 32'd2, 32'd3, 0, 0);
    tick(0, 0, 0, 0, 0, 0);
    check("rst_fresh_valid",  32'(s_valid), 32'd1);
    check("rst_fresh_result", s_result,     32'd6);

    // Random traffic against the model.
    for (int k = 0; k < 1500; k++) begin
      tick(($urandom % 100) < 60, 3'($urandom), $urandom,
           (($urandom % 4) == 0) ? 32'd0 : $urandom,
           ($urandom % 100) < 4, ($urandom % 200) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
